iir_sos_tdm: RTL and testbench

- Parametrised successor to the fixed 4-section cascaded biquad filter top.
- A single time-multiplexed MAC processes N_SECT Direct-Form-I second-order sections in turn for each input sample.
- Coefficients are loaded at run time through a write port; per-section state is held in registers.
- Sits between the sample source and the output/capture logic; counts N_SAMPLES outputs per run and then signals done.

---
 rtl/iir_pkg.sv | 59 +++++
 rtl/iir_sos_tdm_mac.sv | 58 +++++
 rtl/iir_sos_tdm.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_iir_sos_tdm.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iir_pkg
// Description : Shared constants, state encoding and the round/saturate
//               helper for the time-multiplexed biquad cascade.
// Revision    : 1.0 - initial release
// ============================================================================
package iir_pkg;

    // Coefficient slot indices inside one section
    localparam logic [2:0] c_b0 = 3'd0;
    localparam logic [2:0] c_b1 = 3'd1;
    localparam logic [2:0] c_b2 = 3'd2;
    localparam logic [2:0] c_a1 = 3'd3;
    localparam logic [2:0] c_a2 = 3'd4;
    localparam int         c_n_coef = 5;

    // Controller state encoding
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_wait_in = 3'd1;
    localparam logic [2:0] c_st_mac     = 3'd2;
    localparam logic [2:0] c_st_out     = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    // MAC unit control: hold, start a new sum, add to the running sum
    localparam logic [1:0] c_op_hold = 2'd0;
    localparam logic [1:0] c_op_clr  = 2'd1;
    localparam logic [1:0] c_op_acc  = 2'd2;

    typedef struct packed {
        logic              hit;
        logic signed [63:0] val;
    } sat_res_t;

    // Round half-up at the binary point, then clamp to a dw-bit signed range.
    // Works on a 64-bit container so any accumulator up to 64 bits fits.
    function automatic sat_res_t round_sat(input logic signed [63:0] acc,
                                           input int dw, input int cfrac);
        sat_res_t           res;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r       = (acc + (64'sd1 <<< (cfrac - 1))) >>> cfrac;
        hi      = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (dw - 1));
        res.hit = 1'b0;
        res.val = r;
        if (r > hi) begin
            res.val = hi;
            res.hit = 1'b1;
        end else if (r < lo) begin
            res.val = lo;
            res.hit = 1'b1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iir_sos_tdm_mac.sv
`default_nettype none
// ============================================================================
// Module      : iir_mac_unit
// Description : Signed multiply-accumulate with round-half-up and saturation
//               of the running sum back to the data width. The finished
//               result and its saturation flag are combinational views of
//               the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_mac_unit
    import iir_pkg::*;
#(
    parameter int DW    = 24,
    parameter int CW    = 24,
    parameter int AW    = 48,
    parameter int CFRAC = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           op,
    input  logic                 sub,
    input  logic signed [DW-1:0] data,
    input  logic signed [CW-1:0] coef,
    output logic signed [DW-1:0] result,
    output logic                 sat_hit
);

    logic signed [DW+CW-1:0] w_prod;
    logic signed [AW-1:0]    w_term;
    logic signed [AW-1:0]    r_acc;
    sat_res_t                w_fin;
    logic                    w_unused_hi;

    // The full product fits in DW+CW bits, so it is negated only after
    // widening to AW; this keeps -(min*min) representable.
    assign w_prod = (DW+CW)'(data) * (DW+CW)'(coef);
    assign w_term = sub ? -AW'(w_prod) : AW'(w_prod);

    // Accumulator: load first product of a section, then add the rest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            case (op)
                c_op_clr: r_acc <= w_term;
                c_op_acc: r_acc <= r_acc + w_term;
                default:  r_acc <= r_acc;
            endcase
        end
    end

    assign w_fin       = round_sat(64'(r_acc), DW, CFRAC);
    assign result      = w_fin.val[DW-1:0];
    assign sat_hit     = w_fin.hit;
    assign w_unused_hi = ^w_fin.val[63:DW];

endmodule
`default_nettype wire

// File: rtl/iir_sos_tdm.sv
`default_nettype none
// ============================================================================
// Module      : iir_sos_tdm
// Description : N_SECT cascaded Direct-Form-I biquads sharing one MAC, five
//               products per section per sample. Coefficients are written at
//               run time while idle or done; a run ends after N_SAMPLES
//               outputs. Optional output-settling detector is built when
//               IIR_STABLE_DETECT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_sos_tdm
    import iir_pkg::*;
#(
    parameter int DW         = 24,
    parameter int CW         = 24,
    parameter int CFRAC      = 22,
    parameter int AW         = 48,
    parameter int N_SECT     = 4,
    parameter int N_SAMPLES  = 2048,
    parameter int ADDR_W     = 11,
    parameter int STB_THRESH = 16,
    parameter int STB_COUNT  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [DW-1:0]  data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    input  logic                  coef_we,
    input  logic [3:0]            coef_sect,
    input  logic [2:0]            coef_idx,
    input  logic signed [CW-1:0]  coef_wdata,
    output logic                  busy,
    output logic                  filter_done,
    output logic [ADDR_W-1:0]     addr,
    output logic signed [DW-1:0]  data_out,
    output logic                  data_out_valid,
    output logic                  sat_flag,
    output logic                  stable_out
);

    localparam logic signed [CW-1:0] c_coef_one = CW'(1) << CFRAC;

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [3:0]           r_sect;
    logic [2:0]           r_phase;
    logic [ADDR_W-1:0]    r_idx;
    logic [ADDR_W-1:0]    r_addr;
    logic signed [DW-1:0] r_dout;
    logic                 r_dval;
    logic                 r_sat;
    logic signed [DW-1:0] r_x;

    logic signed [DW-1:0] r_x1 [N_SECT];
    logic signed [DW-1:0] r_x2 [N_SECT];
    logic signed [DW-1:0] r_y1 [N_SECT];
    logic signed [DW-1:0] r_y2 [N_SECT];
    logic signed [CW-1:0] r_coef [N_SECT][c_n_coef];

    logic                 w_cfg_ok;
    logic                 w_start_ok;
    logic                 w_last_prod;
    logic                 w_fin;
    logic signed [CW-1:0] w_cb [c_n_coef];
    logic signed [DW-1:0] w_sx1, w_sx2, w_sy1, w_sy2;
    logic signed [DW-1:0] w_x;
    logic [1:0]           w_op;
    logic                 w_sub;
    logic signed [CW-1:0] w_coef;
    logic signed [DW-1:0] w_data;
    logic signed [DW-1:0] w_res;
    logic                 w_hit;

    assign w_cfg_ok    = (r_state == c_st_idle) || (r_state == c_st_done);
    assign w_start_ok  = start && w_cfg_ok;
    assign w_last_prod = (r_phase == 3'd4) && (r_sect == 4'(N_SECT - 1));
    // The accumulator holds a finished section result at the first product of
    // the following section and during OUT.
    assign w_fin       = ((r_state == c_st_mac) && (r_phase == 3'd0) && (r_sect != 4'd0))
                         || (r_state == c_st_out);

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_next;
    end

    // Next-state and status decode
    always_comb begin
        w_next        = r_state;
        busy          = 1'b0;
        filter_done   = 1'b0;
        data_in_ready = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) w_next = c_st_wait_in;
            end
            c_st_wait_in: begin
                busy          = 1'b1;
                data_in_ready = 1'b1;
                if (data_in_valid) w_next = c_st_mac;
            end
            c_st_mac: begin
                busy = 1'b1;
                if (w_last_prod) w_next = c_st_out;
            end
            c_st_out: begin
                busy = 1'b1;
                if (r_idx == ADDR_W'(N_SAMPLES - 1)) w_next = c_st_done;
                else                                 w_next = c_st_wait_in;
            end
            c_st_done: begin
                filter_done = 1'b1;
                if (start) w_next = c_st_wait_in;
            end
            default: w_next = c_st_idle;
        endcase
    end

    // Select the current section's coefficients and history
    always_comb begin
        for (int k = 0; k < c_n_coef; k++) w_cb[k] = '0;
        w_sx1 = '0;
        w_sx2 = '0;
        w_sy1 = '0;
        w_sy2 = '0;
        for (int s = 0; s < N_SECT; s++) begin
            if (r_sect == 4'(s)) begin
                for (int k = 0; k < c_n_coef; k++) w_cb[k] = r_coef[s][k];
                w_sx1 = r_x1[s];
                w_sx2 = r_x2[s];
                w_sy1 = r_y1[s];
                w_sy2 = r_y2[s];
            end
        end
    end

    // Section 0 takes the accepted sample; later sections chain the previous result
    assign w_x = (r_sect == 4'd0) ? r_x : w_res;

    // Operand sequence: b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2
    always_comb begin
        w_op   = c_op_hold;
        w_sub  = 1'b0;
        w_coef = w_cb[c_b0];
        w_data = w_x;
        if (r_state == c_st_mac) begin
            w_op = (r_phase == 3'd0) ? c_op_clr : c_op_acc;
            case (r_phase)
                3'd1:    begin w_coef = w_cb[c_b1]; w_data = w_sx1; end
                3'd2:    begin w_coef = w_cb[c_b2]; w_data = w_sx2; end
                3'd3:    begin w_coef = w_cb[c_a1]; w_data = w_sy1; w_sub = 1'b1; end
                3'd4:    begin w_coef = w_cb[c_a2]; w_data = w_sy2; w_sub = 1'b1; end
                default: begin w_coef = w_cb[c_b0]; w_data = w_x; end
            endcase
        end
    end

    iir_mac_unit #(
        .DW    (DW),
        .CW    (CW),
        .AW    (AW),
        .CFRAC (CFRAC)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .op      (w_op),
        .sub     (w_sub),
        .data    (w_data),
        .coef    (w_coef),
        .result  (w_res),
        .sat_hit (w_hit)
    );

    // Datapath: sequencing counters, section history, coefficients, outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sect  <= '0;
            r_phase <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_dout  <= '0;
            r_dval  <= 1'b0;
            r_sat   <= 1'b0;
            r_x     <= '0;
            for (int s = 0; s < N_SECT; s++) begin
                r_x1[s] <= '0;
                r_x2[s] <= '0;
                r_y1[s] <= '0;
                r_y2[s] <= '0;
                for (int k = 0; k < c_n_coef; k++)
                    r_coef[s][k] <= (k == 0) ? c_coef_one : '0;
            end
        end else begin
            r_dval <= 1'b0;
            if (w_fin && w_hit) r_sat <= 1'b1;

            if (w_start_ok) begin
                r_idx  <= '0;
                r_addr <= '0;
                r_sat  <= 1'b0;
                for (int s = 0; s < N_SECT; s++) begin
                    r_x1[s] <= '0;
                    r_x2[s] <= '0;
                    r_y1[s] <= '0;
                    r_y2[s] <= '0;
                end
            end

            // Out-of-range section or slot simply matches nothing
            if (coef_we && w_cfg_ok) begin
                for (int s = 0; s < N_SECT; s++)
                    for (int k = 0; k < c_n_coef; k++)
                        if (coef_sect == 4'(s) && coef_idx == 3'(k))
                            r_coef[s][k] <= coef_wdata;
            end

            case (r_state)
                c_st_wait_in: begin
                    if (data_in_valid) begin
                        r_x     <= data_in;
                        r_sect  <= '0;
                        r_phase <= '0;
                    end
                end
                c_st_mac: begin
                    if (r_phase == 3'd4) begin
                        r_phase <= '0;
                        r_sect  <= r_sect + 4'd1;
                    end else begin
                        r_phase <= r_phase + 3'd1;
                    end
                    if (r_phase == 3'd0) begin
                        r_x <= w_x;
                        // Retire the previous section now that its result is final
                        for (int s = 0; s < N_SECT - 1; s++) begin
                            if (r_sect == 4'(s + 1)) begin
                                r_x2[s] <= r_x1[s];
                                r_x1[s] <= r_x;
                                r_y2[s] <= r_y1[s];
                                r_y1[s] <= w_res;
                            end
                        end
                    end
                end
                c_st_out: begin
                    r_x2[N_SECT-1] <= r_x1[N_SECT-1];
                    r_x1[N_SECT-1] <= r_x;
                    r_y2[N_SECT-1] <= r_y1[N_SECT-1];
                    r_y1[N_SECT-1] <= w_res;
                    r_dout <= w_res;
                    r_dval <= 1'b1;
                    r_addr <= r_idx;
                    r_idx  <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign addr           = r_addr;
    assign data_out       = r_dout;
    assign data_out_valid = r_dval;
    assign sat_flag       = r_sat;

`ifdef IIR_STABLE_DETECT_EN
    localparam int c_stb_w = $clog2(STB_COUNT + 1);

    logic [c_stb_w-1:0]  r_stb_cnt;
    logic signed [DW:0]  w_diff;
    logic [DW:0]         w_adiff;

    // r_dout still holds y[n-1] while OUT computes y[n]
    assign w_diff  = (DW+1)'(w_res) - (DW+1)'(r_dout);
    assign w_adiff = w_diff[DW] ? (DW+1)'(-w_diff) : (DW+1)'(w_diff);

    // Saturating count of consecutive quiet outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb_cnt <= '0;
        end else if (w_start_ok) begin
            r_stb_cnt <= '0;
        end else if (r_state == c_st_out) begin
            if (w_adiff < (DW+1)'(STB_THRESH)) begin
                if (r_stb_cnt != c_stb_w'(STB_COUNT)) r_stb_cnt <= r_stb_cnt + 1'b1;
            end else begin
                r_stb_cnt <= '0;
            end
        end
    end

    assign stable_out = (r_stb_cnt >= c_stb_w'(STB_COUNT));
`else
    localparam int c_unused_stb = STB_THRESH + STB_COUNT;
    assign stable_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iir_sos_tdm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_iir_sos_tdm
// Description : Directed scoreboard bench for iir_sos_tdm. Stimulus pushes
//               hand-computed outputs; a monitor pops on data_out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_sos_tdm;

`ifdef IIR_STABLE_DETECT_EN
    localparam int NS      = 72;
    localparam bit EXP_STB = 1'b1;
`else
    localparam int NS      = 8;
    localparam bit EXP_STB = 1'b0;
`endif
    localparam int LAT = 21;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic signed [23:0] data_in = '0;
    logic               data_in_valid = 1'b0;
    logic               data_in_ready;
    logic               coef_we = 1'b0;
    logic [3:0]         coef_sect = '0;
    logic [2:0]         coef_idx = '0;
    logic signed [23:0] coef_wdata = '0;
    logic               busy;
    logic               filter_done;
    logic [6:0]         addr;
    logic signed [23:0] data_out;
    logic               data_out_valid;
    logic               sat_flag;
    logic               stable_out;

    typedef struct {
        logic signed [23:0] data;
        logic [6:0]         addr;
        int                 cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   exp_addr = 0;

    iir_sos_tdm #(
        .N_SAMPLES (NS),
        .ADDR_W    (7)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .coef_we        (coef_we),
        .coef_sect      (coef_sect),
        .coef_idx       (coef_idx),
        .coef_wdata     (coef_wdata),
        .busy           (busy),
        .filter_done    (filter_done),
        .addr           (addr),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .sat_flag       (sat_flag),
        .stable_out     (stable_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents an output
    always @(negedge clk) begin
        if (rst_n && data_out_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_bad++;
                $display("FAIL unexpected_output: got %0d expected none", data_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data_out", data_out, e.data);
                chk("addr", addr, e.addr);
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Tasks start and end on a falling edge
    task automatic send(input logic signed [23:0] v, input logic signed [23:0] e);
        int   n = 0;
        exp_t x;
        data_in       = v;
        data_in_valid = 1'b1;
        while (!data_in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!data_in_ready) begin
            n_chk++;
            n_bad++;
            $display("FAIL send_timeout: ready=%0b expected 1", data_in_ready);
        end else begin
            x.data = e;
            x.addr = 7'(exp_addr);
            x.cyc  = cyc + 1 + LAT;
            q.push_back(x);
            exp_addr++;
        end
        @(negedge clk);
        data_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL drain_timeout: pending=%0d expected 0", q.size());
        end
        q.delete();
        @(negedge clk);
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = 0;
    endtask

    task automatic wcoef(input int s, input int k, input logic signed [23:0] v);
        coef_we    = 1'b1;
        coef_sect  = 4'(s);
        coef_idx   = 3'(k);
        coef_wdata = v;
        @(negedge clk);
        coef_we    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        q.delete();
        exp_addr = 0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, filter_done, 0);
        chk({tag, "_ready"}, data_in_ready, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_dout"}, data_out, 0);
        chk({tag, "_dval"}, data_out_valid, 0);
        chk({tag, "_sat"}, sat_flag, 0);
        chk({tag, "_stable"}, stable_out, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: time=%0t expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: passthrough, ignored start mid-run
        start_run();
        chk("t1_busy", busy, 1);
        chk("t1_ready", data_in_ready, 1);
        send(24'sd100, 24'sd100);
        send(-24'sd5, -24'sd5);
        send(24'sd8388607, 24'sd8388607);
        start_run();
        exp_addr = 3;
        send(24'sd42, 24'sd42);
        drain();
        chk("t1_sat", sat_flag, 0);
        chk("t1_busy_after", busy, 1);
        do_reset();

        // 2: gain 0.5 with half-up rounding of a negative value
        wcoef(0, 0, 24'sh200000);
        start_run();
        send(24'sd1000, 24'sd500);
        send(-24'sd3, -24'sd1);
        send(24'sd0, 24'sd0);
        drain();
        do_reset();

        // 3: first-order recursion y = x + 0.5*y1
        wcoef(0, 3, 24'shE00000);
        start_run();
        e = 1024;
        for (int i = 0; i < NS; i++) begin
            send((i == 0) ? 24'sd1024 : 24'sd0, 24'(e));
            e = (e + 1) / 2;
        end
        drain();
        chk("t3_done", filter_done, 1);
        do_reset();

        // 4: saturation at both rails, sticky until start
        wcoef(0, 0, 24'sh7FFFFF);
        start_run();
        send(24'sd8388607, 24'sd8388607);
        drain();
        chk("t4_sat_set", sat_flag, 1);
        send(-24'sd8388608, -24'sd8388608);
        send(24'sd1000, 24'sd2000);
        while (exp_addr < NS) send(24'sd0, 24'sd0);
        drain();
        chk("t4_done", filter_done, 1);
        chk("t4_sat_sticky", sat_flag, 1);
        start_run();
        chk("t4_sat_cleared", sat_flag, 0);
        chk("t4_done_cleared", filter_done, 0);
        do_reset();

        // 5: run end, dropped mid-run write, re-run with cleared history
        start_run();
        wcoef(0, 0, 24'sd0);
        for (int i = 0; i < NS; i++) send(24'sd7, 24'sd7);
        drain();
        chk("t5_done", filter_done, 1);
        chk("t5_ready", data_in_ready, 0);
        chk("t5_busy", busy, 0);
        chk("t5_addr", addr, NS - 1);
        chk("t5_stable", stable_out, EXP_STB);
        wcoef(0, 1, 24'sh400000);
        wcoef(3, 0, 24'shC00000);
        start_run();
        chk("t5_restart_done", filter_done, 0);
        chk("t5_restart_addr", addr, 0);
        send(24'sd3, -24'sd3);
        send(24'sd4, -24'sd7);
        drain();
        do_reset();

        // 6: asynchronous reset in the middle of MAC
        wcoef(0, 0, 24'sh200000);
        start_run();
        send(24'sd50, 24'sd25);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst_n = 1'b1;
        exp_addr = 0;
        @(negedge clk);
        start_run();
        send(24'sd50, 24'sd50);
        drain();
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
